// File: rtl/seq_div_if.sv
// Request/result bundle for the sequential restoring divider.
// start/dividend/divisor: one-cycle request, taken only while idle; done marks a valid result.
interface seq_div_if #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
);
    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Results land on the output registers only on entry to DONE.
module seq_div #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_div_if.slave   bus,
    output logic [1:0] dbg_state
);
    localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DVD_W-1:0]   dvd_q, dvd_d;
    logic [DVS_W-1:0]   dvs_q, dvs_d;
    logic [DVS_W:0]     rem_q, rem_d;
    logic [DVD_W-1:0]   acc_q, acc_d;
    logic [DVD_W-1:0]   quo_q, quo_d;
    logic [DVS_W-1:0]   rmd_q, rmd_d;
    logic               dbz_q, dbz_d;

    logic [DVS_W:0]     s;
    logic               ge;
    logic [DVS_W:0]     r_next;
    logic [DVD_W-1:0]   acc_next;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        rmd_d    = rmd_q;
        dbz_d    = dbz_q;

        // The dividend register shifts left so its MSB is always the next bit to bring down.
        s        = {rem_q[DVS_W-1:0], dvd_q[DVD_W-1]};
        ge       = (s >= {1'b0, dvs_q});
        r_next   = ge ? (s - {1'b0, dvs_q}) : s;
        acc_next = {acc_q[DVD_W-2:0], ge};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d = bus.dividend;
                    dvs_d = bus.divisor;
                    rem_d = '0;
                    acc_d = '0;
                    cnt_d = CNT_W'(DVD_W - 1);
                    dbz_d = 1'b0;
                    if (bus.divisor == '0) begin
                        quo_d   = '1;
                        rmd_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = r_next;
                acc_d = acc_next;
                dvd_d = dvd_q << 1;
                if (cnt_q == '0) begin
                    quo_d   = acc_next;
                    rmd_d   = r_next[DVS_W-1:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == CALC);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed and random bench for seq_div; expected results come from a / and % model
// through a scoreboard queue popped on every done pulse.
module tb_seq_div;
  localparam int DVD_W = 8;
  localparam int DVS_W = 4;
  localparam int RW = DVD_W + DVS_W + 1;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  seq_div_if #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dif ();

  seq_div #(.DVD_W(DVD_W), .DVS_W(DVS_W)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(dif.slave),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] model(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b);
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
    if (b == 0) return {{DVD_W{1'b1}}, {DVS_W{1'b0}}, 1'b1};
    q = DVD_W'(a / b);
    r = DVS_W'(a % b);
    return {q, r, 1'b0};
  endfunction

  // scoreboard: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && dif.done) begin
      n_vec++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_done: observed q=%0d r=%0d dbz=%0b with nothing expected",
               dif.quotient, dif.remainder, dif.div_by_zero);
      end
      if (exp_q.size() > 0) begin
        check("result", {dif.quotient, dif.remainder, dif.div_by_zero}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int k = 0;
    while (dbg_state != 2'd0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("idle_before_start", dbg_state, 2'd0);
  endtask

  // Returns at the first negedge after the accepting posedge.
  task automatic start_div(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b, input bit push);
    wait_idle();
    dif.start = 1'b1;
    dif.dividend = a;
    dif.divisor = b;
    if (push) exp_q.push_back(model(a, b));
    @(negedge clk);
    dif.start = 1'b0;
    dif.dividend = DVD_W'($urandom_range(0, 255));
    dif.divisor = DVS_W'($urandom_range(0, 15));
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!dif.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b);
    int lat;
    start_div(a, b, 1'b1);
    wait_done(lat);
    check("latency", lat, (b == 0) ? 1 : DVD_W + 1);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int bc;
    bit seen_done;
    logic [DVD_W-1:0] ra;
    logic [DVS_W-1:0] rb;

    rst_n = 1'b0;
    dif.start = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vectors
    run(8'd200, 4'd7);
    run(8'd255, 4'd1);
    run(8'd255, 4'd15);
    run(8'd5, 4'd9);
    run(8'd0, 4'd3);
    run(8'd100, 4'd0);
    check("dbz_hold", dif.div_by_zero, 1'b1);
    run(8'd9, 4'd2);
    check("dbz_cleared", dif.div_by_zero, 1'b0);

    // start during CALC is ignored; busy lasts exactly DVD_W cycles
    start_div(8'd200, 4'd7, 1'b1);
    lat = 1;
    bc = 0;
    while (!dif.done && lat < 40) begin
      if (dif.busy) bc++;
      if (lat == 3) begin
        dif.start = 1'b1;
        dif.dividend = 8'd9;
        dif.divisor = 4'd2;
      end else begin
        dif.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    dif.start = 1'b0;
    check("ignored_start_latency", lat, DVD_W + 1);
    check("busy_cycles", bc, DVD_W);
    @(negedge clk);
    check("no_queued_start", dbg_state, 2'd0);

    // reset in the middle of a division aborts it with no done pulse
    start_div(8'd200, 4'd7, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs", {dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero}, 0);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (dif.done) seen_done = 1'b1;
    end
    check("no_done_after_abort", seen_done, 1'b0);
    run(8'd13, 4'd3);

    // start held high: a second division begins on the return to IDLE
    wait_idle();
    dif.start = 1'b1;
    dif.dividend = 8'd50;
    dif.divisor = 4'd6;
    exp_q.push_back(model(8'd50, 4'd6));
    exp_q.push_back(model(8'd50, 4'd6));
    @(negedge clk);
    wait_done(lat);
    check("held_first_latency", lat, DVD_W + 1);
    @(negedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    wait_done(lat);
    check("held_second_latency", lat, DVD_W + 1);
    @(negedge clk);

    // random operands
    for (int i = 0; i < 10; i++) begin
      ra = DVD_W'($urandom_range(0, 255));
      rb = DVS_W'($urandom_range(0, 15));
      run(ra, rb);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
